shift_subtract_divider: RTL and testbench
=========================================

SHIFT_SUBTRACT_DIVIDER -- requirements
Module: shift_subtract_divider

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-low reset; its ports SHALL be named clk and rst.
REQ-002 Parameter DW SHALL be named DW, default 8, and SHALL set the dividend and quotient width.
REQ-003 Parameter VW SHALL be named VW, default 4, and SHALL set the divisor and remainder width; DW SHALL be at least VW.
REQ-004 clk SHALL be an input, 1 bit wide: the rising-edge clock.
REQ-005 rst SHALL be an input, 1 bit wide: 0 resets the block asynchronously.
REQ-006 start SHALL be an input, 1 bit wide: requests an operation and is honoured only while ready=1.
REQ-007 dividendBus SHALL be an input, DW bits wide: the dividend, sampled when start is accepted.
REQ-008 divisorBus SHALL be an input, VW bits wide: the divisor, sampled when start is accepted.
REQ-009 ready SHALL be an output, 1 bit wide: 1 means idle and the result outputs are valid.
REQ-010 quotientBus SHALL be an output, DW bits wide: the registered quotient.
REQ-011 remainderBus SHALL be an output, VW bits wide: the registered remainder.
REQ-012 dbz SHALL be an output, 1 bit wide: set when the last operation had divisor 0.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE (ready=1) and CALC (ready=0).
REQ-014 On a rising edge in IDLE with start=1, the block SHALL perform all of the following on that edge:
- latch dividendBus into shift register Q (DW bits);
- latch divisorBus into D (VW bits);
- clear partial remainder R (VW+1 bits);
- clear the step counter;
- go to CALC.
REQ-015 Each CALC edge SHALL perform one restoring step:
- T = {R[VW-1:0], Q[DW-1]};
- if T >= {1'b0, D}, then R = T - D and shift 1 into Q[0];
- otherwise R = T and shift 0 into Q[0];
- Q shifts left by one.
REQ-016 After exactly DW CALC edges, the block SHALL load Q into quotientBus, load R[VW-1:0] into remainderBus, clear dbz, and return to IDLE.
REQ-017 Latency: if start is accepted at edge k, ready SHALL be 0 after edges k through k+DW-1, and SHALL be 1 with valid results after edge k+DW (8 edges at default widths).
REQ-018 If the divisor latched at acceptance is 0, the block SHALL skip CALC entirely: on that same edge it stays in IDLE, sets quotientBus to all ones, sets remainderBus to 0, and sets dbz=1.
REQ-019 quotientBus, remainderBus and dbz SHALL hold their previous values throughout CALC; intermediate values SHALL never be visible on them.
REQ-020 start asserted during CALC SHALL be ignored; it SHALL NOT be queued.
REQ-021 If start is held high, a new operation SHALL be accepted on the first IDLE edge after completion, so ready is high for exactly one cycle between back-to-back operations.
REQ-022 All arithmetic SHALL be unsigned, and the result SHALL satisfy dividend = quotient*divisor + remainder with remainder < divisor.

Reset
REQ-023 While rst=0, the block SHALL force state=IDLE, ready=1, quotientBus=0, remainderBus=0, dbz=0, and clear Q, D, R and the counter, regardless of the clock.
REQ-024 A reset that arrives during CALC SHALL abort the operation with no partial result output; the first start after rst deasserts SHALL behave exactly as after power-up.

Structure
REQ-025 A shared package div_pkg SHALL hold the state enumeration (IDLE, CALC) and the default DW and VW values.
REQ-026 The compare-subtract step SHALL be a combinational sub-module named div_step, taking R, the incoming dividend bit and D, and producing the next R and the quotient bit.
REQ-027 The counter SHALL be sized as clog2(DW)+1 bits, and all state SHALL reside in the top-level module.

Verification
REQ-028 Dividend 100, divisor 7, start for one cycle: the bench SHALL see ready low for 8 cycles, then quotient=14, remainder=2, dbz=0.
REQ-029 Dividend 255 with divisor 15, then dividend 255 with divisor 1: the bench SHALL see quotient 17 with remainder 0, then quotient 255 with remainder 0.
REQ-030 Dividend 5, divisor 9: the bench SHALL see quotient 0, remainder 5; dividend 13, divisor 0: the bench SHALL see ready stay 1, quotient 0xFF, remainder 0, dbz=1 on the next cycle.
REQ-031 Start 200/3, pulse start again 3 cycles later with 50/5: the second pulse SHALL be ignored and the result SHALL be quotient 66, remainder 2.
REQ-032 Start 200/3, drive rst=0 after 4 cycles: outputs SHALL clear immediately; after release, 9/2 SHALL give quotient 4, remainder 1.
REQ-033 Start held high continuously over 77/6 then 77/6 again: two completions 9 cycles apart, each giving quotient 12, remainder 5.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the shift/subtract divider.
// Holds the two-state FSM encoding and the default operand widths.
package div_pkg;

  localparam int DW_DEFAULT = 8;  // dividend / quotient width
  localparam int VW_DEFAULT = 4;  // divisor / remainder width

  typedef enum logic {
    IDLE = 1'b0,  // ready=1, result outputs valid
    CALC = 1'b1   // one restoring step per clock
  } state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division step (purely combinational).
//
// Ports:
//   r      - partial remainder R (VW+1 bits)
//   bit_in - next dividend bit, shifted into the bottom of R
//   d      - divisor D (VW bits)
//   r_next - partial remainder after the compare/subtract
//   q_bit  - quotient bit produced by this step
module div_step
  import div_pkg::*;
#(
  parameter int VW = VW_DEFAULT
) (
  input  logic [VW:0]   r,
  input  logic          bit_in,
  input  logic [VW-1:0] d,
  output logic [VW:0]   r_next,
  output logic          q_bit
);

  // R < D is invariant between steps, so r[VW] is always 0. Using the
  // full R here gives the same value as {R[VW-1:0], bit_in} and keeps
  // every input bit in the logic cone.
  logic [VW+1:0] t;
  logic [VW+1:0] d_ext;

  assign t     = {r, bit_in};
  assign d_ext = {2'b00, d};

  // NOTE: every output of a combinational block gets a default first so
  // that no path through the block leaves it unassigned (no latch).
  always_comb begin
    r_next = t[VW:0];
    q_bit  = 1'b0;
    if (t >= d_ext) begin
      r_next = (VW+1)'(t - d_ext);
      q_bit  = 1'b1;
    end
  end

endmodule : div_step

// File: rtl/shift_subtract_divider.sv
// Sequential unsigned restoring divider: one quotient bit per clock.
// A start accepted in IDLE latches the operands; DW CALC cycles later the
// quotient and remainder are published and the block is ready again.
// A zero divisor is flagged immediately without entering CALC.
// DW must be at least VW.
//
// Ports:
//   clk          - rising-edge clock
//   rst          - asynchronous, active-low reset
//   start        - request an operation (honoured only while ready=1)
//   dividendBus  - dividend (DW bits), sampled on acceptance
//   divisorBus   - divisor (VW bits), sampled on acceptance
//   ready        - 1 = idle, result outputs valid
//   quotientBus  - registered quotient (DW bits)
//   remainderBus - registered remainder (VW bits)
//   dbz          - last operation had divisor 0
module shift_subtract_divider
  import div_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int VW = VW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividendBus,
  input  logic [VW-1:0] divisorBus,
  output logic          ready,
  output logic [DW-1:0] quotientBus,
  output logic [VW-1:0] remainderBus,
  output logic          dbz
);

  localparam int CW = $clog2(DW) + 1;

  state_t        state, state_next;
  logic [DW-1:0] q_reg;
  logic [VW-1:0] d_reg;
  logic [VW:0]   r_reg;
  logic [CW-1:0] cnt;

  logic [VW:0]   r_step;
  logic          q_bit;
  logic [DW-1:0] q_step;
  logic          accept;
  logic          last_step;

  div_step #(.VW(VW)) u_step (
    .r      (r_reg),
    .bit_in (q_reg[DW-1]),
    .d      (d_reg),
    .r_next (r_step),
    .q_bit  (q_bit)
  );

  // Q shifted left with the new quotient bit entering at bit 0.
  assign q_step    = DW'({q_reg, q_bit});
  assign accept    = (state == IDLE) && start;
  assign last_step = (cnt == CW'(DW - 1));

  // Next-state and ready decode.
  always_comb begin
    state_next = state;
    ready      = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        // A zero divisor is answered on the acceptance edge itself.
        if (start && (divisorBus != '0)) state_next = CALC;
      end
      CALC: begin
        if (last_step) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath and result registers. Results change only on the acceptance
  // edge (zero divisor) or the final CALC edge, so intermediate values are
  // never visible outside.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg        <= '0;
      d_reg        <= '0;
      r_reg        <= '0;
      cnt          <= '0;
      quotientBus  <= '0;
      remainderBus <= '0;
      dbz          <= 1'b0;
    end else if (accept) begin
      q_reg <= dividendBus;
      d_reg <= divisorBus;
      r_reg <= '0;
      cnt   <= '0;
      if (divisorBus == '0) begin
        quotientBus  <= '1;
        remainderBus <= '0;
        dbz          <= 1'b1;
      end
    end else if (state == CALC) begin
      q_reg <= q_step;
      r_reg <= r_step;
      cnt   <= cnt + CW'(1);
      if (last_step) begin
        quotientBus  <= q_step;
        remainderBus <= r_step[VW-1:0];
        dbz          <= 1'b0;
      end
    end
  end

endmodule : shift_subtract_divider

// File: tb/tb_shift_subtract_divider.sv
// Directed self-checking bench for shift_subtract_divider (DW=8, VW=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_shift_subtract_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividendBus;
  logic [3:0] divisorBus;
  logic       ready;
  logic [7:0] quotientBus;
  logic [3:0] remainderBus;
  logic       dbz;

  int tests  = 0;
  int failed = 0;

  shift_subtract_divider #(.DW(8), .VW(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .dividendBus  (dividendBus),
    .divisorBus   (divisorBus),
    .ready        (ready),
    .quotientBus  (quotientBus),
    .remainderBus (remainderBus),
    .dbz          (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    tests++;
    assert (observed === expected)
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Present operands with start high for exactly one rising edge. Returns
  // at the falling edge right after the acceptance edge.
  task automatic pulse(input logic [7:0] dvd, input logic [3:0] dvs);
    dividendBus = dvd;
    divisorBus  = dvs;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count falling edges (including the current one) on which ready is low.
  task automatic wait_ready(output int busy);
    busy = 0;
    while (!ready && busy < 50) begin
      busy++;
      @(negedge clk);
    end
  endtask

  int busy;
  int cyc;
  int done_at[2];
  int n_done;
  logic prev_ready;

  initial begin
    rst         = 1'b0;
    start       = 1'b0;
    dividendBus = '0;
    divisorBus  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_quot", quotientBus, 0);
    check("rst_rem", remainderBus, 0);
    check("rst_dbz", dbz, 0);
    rst = 1'b1;
    @(negedge clk);

    // 100 / 7 : eight busy cycles, q=14 r=2.
    pulse(8'd100, 4'd7);
    check("100_7_busy_quot_hold", quotientBus, 0);
    wait_ready(busy);
    check("100_7_latency", busy, 8);
    check("100_7_quot", quotientBus, 14);
    check("100_7_rem", remainderBus, 2);
    check("100_7_dbz", dbz, 0);

    // 255 / 15 then 255 / 1.
    @(negedge clk);
    pulse(8'd255, 4'd15);
    wait_ready(busy);
    check("255_15_latency", busy, 8);
    check("255_15_quot", quotientBus, 17);
    check("255_15_rem", remainderBus, 0);
    @(negedge clk);
    pulse(8'd255, 4'd1);
    wait_ready(busy);
    check("255_1_quot", quotientBus, 255);
    check("255_1_rem", remainderBus, 0);

    // Divisor larger than dividend.
    @(negedge clk);
    pulse(8'd5, 4'd9);
    wait_ready(busy);
    check("5_9_quot", quotientBus, 0);
    check("5_9_rem", remainderBus, 5);

    // Divide by zero: no busy cycle, flagged result on the acceptance edge.
    @(negedge clk);
    pulse(8'd13, 4'd0);
    check("dbz_ready", ready, 1);
    check("dbz_quot", quotientBus, 8'hFF);
    check("dbz_rem", remainderBus, 0);
    check("dbz_flag", dbz, 1);

    // 200 / 3 with a second start 3 cycles in, which must be ignored.
    pulse(8'd200, 4'd3);
    repeat (2) @(negedge clk);
    pulse(8'd50, 4'd5);
    check("ign_busy", ready, 0);
    check("ign_quot_hold", quotientBus, 8'hFF);
    check("ign_dbz_hold", dbz, 1);
    wait_ready(busy);
    check("ign_latency", busy, 5);
    check("ign_quot", quotientBus, 66);
    check("ign_rem", remainderBus, 2);
    check("ign_dbz", dbz, 0);
    @(negedge clk);
    check("ign_not_queued", ready, 1);

    // Reset in the middle of 200 / 3, then 9 / 2 from a clean start.
    pulse(8'd200, 4'd3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_ready", ready, 1);
    check("abort_quot", quotientBus, 0);
    check("abort_rem", remainderBus, 0);
    check("abort_dbz", dbz, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse(8'd9, 4'd2);
    wait_ready(busy);
    check("9_2_latency", busy, 8);
    check("9_2_quot", quotientBus, 4);
    check("9_2_rem", remainderBus, 1);

    // Start held high: back-to-back 77 / 6 runs, completions 9 cycles apart.
    @(negedge clk);
    dividendBus = 8'd77;
    divisorBus  = 4'd6;
    start       = 1'b1;
    prev_ready  = ready;
    cyc         = 0;
    n_done      = 0;
    while (n_done < 2 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (ready && !prev_ready) begin
        done_at[n_done] = cyc;
        n_done++;
        check("b2b_quot", quotientBus, 12);
        check("b2b_rem", remainderBus, 5);
      end else if (!ready && n_done == 1) begin
        check("b2b_quot_hold", quotientBus, 12);
      end
      prev_ready = ready;
    end
    start = 1'b0;
    check("b2b_completions", n_done, 2);
    if (n_done == 2) check("b2b_spacing", done_at[1] - done_at[0], 9);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_shift_subtract_divider
